// File: rtl/dac_output_pkg.sv
// Shared types and widths for the DAC output transmitter.
package dac_output_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PLAY
    } state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head word whenever not empty.
module axis_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dac_output_data_transmitter.sv
// AXI-Stream slave that buffers packed sample pairs and replays them as a 16-bit stream, low half first.
module dac_output_data_transmitter
    import dac_output_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                s00_axis_aclk,
    input  logic                s00_axis_areset,
    input  logic                s00_axis_tvalid,
    input  logic [WORD_W-1:0]   s00_axis_tdata,
    input  logic [3:0]          s00_axis_tkeep,
    input  logic                s00_axis_tlast,
    output logic                s00_axis_tready,
    input  logic [31:0]         dsize,
    input  logic                start,
    input  logic                test,
    output logic [SAMPLE_W-1:0] dac_data,
    output logic                dac_valid,
    output logic                sr_pc,
    output logic                sr_underrun,
    output logic                sr_lasterr
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] PRIME_CNT = CW'(PRIME_LEVEL);

    state_t              state;
    state_t              state_next;
    logic [31:0]         len;
    logic [31:0]         rx_cnt;
    logic [31:0]         tx_cnt;
    logic                tmode;
    logic                half;
    logic                start_ok;
    logic                emit;
    logic                accept;
    logic                pop;
    logic [SAMPLE_W-1:0] sample;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [WORD_W-1:0]   fifo_dout;
    logic                unused_tkeep;

    assign unused_tkeep    = ^s00_axis_tkeep;
    assign s00_axis_tready = (state != IDLE) && !tmode && !fifo_full && (rx_cnt < len);
    assign accept          = s00_axis_tvalid && s00_axis_tready;
    assign pop             = emit && half && !tmode;
    // Ramp value is 2*tx_cnt + half, which wraps naturally at 16 bits.
    assign sample          = tmode ? {tx_cnt[14:0], half}
                                   : (half ? fifo_dout[31:16] : fifo_dout[15:0]);

    axis_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (s00_axis_aclk),
        .rst   (s00_axis_areset),
        .push  (accept),
        .pop   (pop),
        .din   (s00_axis_tdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    if (dsize != '0)
                        state_next = FILL;
                end
            end
            FILL: begin
                if (tmode || (rx_cnt == len) || (fifo_count >= PRIME_CNT))
                    state_next = PLAY;
            end
            PLAY: begin
                emit = tmode || !fifo_empty;
                if (emit && half && (tx_cnt == len - 32'd1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            len         <= '0;
            tmode       <= 1'b0;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            half        <= 1'b0;
            dac_data    <= '0;
            dac_valid   <= 1'b0;
            sr_pc       <= 1'b0;
            sr_underrun <= 1'b0;
            sr_lasterr  <= 1'b0;
        end else begin
            // Registered from next state so sr_pc rises together with the final dac_valid.
            sr_pc     <= (state_next == IDLE);
            dac_valid <= emit;
            if (emit) begin
                dac_data <= sample;
                half     <= !half;
                if (half)
                    tx_cnt <= tx_cnt + 32'd1;
            end
            if (accept) begin
                rx_cnt <= rx_cnt + 32'd1;
                if (s00_axis_tlast != (rx_cnt == len - 32'd1))
                    sr_lasterr <= 1'b1;
            end
            if ((state == PLAY) && !emit)
                sr_underrun <= 1'b1;
            if (start_ok) begin
                len         <= dsize;
                tmode       <= test;
                rx_cnt      <= '0;
                tx_cnt      <= '0;
                half        <= 1'b0;
                sr_underrun <= 1'b0;
                sr_lasterr  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_output_data_transmitter.sv
// Self-checking bench: random words, reference sample queue built from packet contents.
module tb_dac_output_data_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hf;
    logic        tlast = 1'b0;
    logic        tready;
    logic [31:0] dsize = '0;
    logic        start = 1'b0;
    logic        test = 1'b0;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic        sr_pc;
    logic        sr_underrun;
    logic        sr_lasterr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [31:0] fixed_words[$];
    int          first_gap;
    int          idx_at_first;
    int          extra_acc;
    logic        last_pc;
    logic        prev_pc;
    bit          tready_seen;

    dac_output_data_transmitter #(
        .FIFO_DEPTH  (16),
        .PRIME_LEVEL (8)
    ) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (tvalid),
        .s00_axis_tdata  (tdata),
        .s00_axis_tkeep  (tkeep),
        .s00_axis_tlast  (tlast),
        .s00_axis_tready (tready),
        .dsize           (dsize),
        .start           (start),
        .test            (test),
        .dac_data        (dac_data),
        .dac_valid       (dac_valid),
        .sr_pc           (sr_pc),
        .sr_underrun     (sr_underrun),
        .sr_lasterr      (sr_lasterr)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one packet and records what comes out; expected samples come from the words themselves.
    task automatic run_packet(input int len, input bit tm, input int tlast_pos, input int valid_pct,
                              input int stall_after, input int stall_cycles, input bit noisy_start,
                              input int abort_at);
        logic [31:0] words[$];
        int idx;
        int stall_left;
        int budget;
        exp_q.delete();
        got_q.delete();
        first_gap    = -1;
        idx_at_first = -1;
        extra_acc    = 0;
        last_pc      = 1'bx;
        prev_pc      = 1'bx;
        tready_seen  = 0;
        for (int i = 0; i < len; i++)
            words.push_back((fixed_words.size() == len) ? fixed_words[i] : $urandom);
        if (tm) begin
            for (int i = 0; i < 2 * len; i++)
                exp_q.push_back(16'(i));
        end else begin
            foreach (words[i]) begin
                exp_q.push_back(words[i][15:0]);
                exp_q.push_back(words[i][31:16]);
            end
        end
        idx        = 0;
        stall_left = stall_cycles;
        budget     = 0;
        @(negedge clk);
        dsize  = len;
        test   = tm;
        start  = 1'b1;
        tvalid = 1'b0;
        forever begin
            @(negedge clk);
            budget++;
            if (dac_valid) begin
                if (got_q.size() == 0)
                    idx_at_first = idx;
                got_q.push_back(dac_data);
                if (got_q.size() == exp_q.size() - 1)
                    prev_pc = sr_pc;
                if (got_q.size() == exp_q.size())
                    last_pc = sr_pc;
            end else if (got_q.size() > 0 && got_q.size() < exp_q.size() && first_gap < 0) begin
                first_gap = got_q.size();
            end
            if (tready)
                tready_seen = 1;
            if (got_q.size() >= exp_q.size() || (abort_at > 0 && got_q.size() >= abort_at)
                || budget > 2000)
                break;
            start = noisy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            dsize = $urandom;
            test  = 1'($urandom);
            if (stall_after >= 0 && idx == stall_after && stall_left > 0) begin
                stall_left--;
                tvalid = 1'b0;
            end else begin
                tvalid = ($urandom_range(1, 100) <= valid_pct);
            end
            tdata = (idx < len) ? words[idx] : $urandom;
            tlast = (idx == tlast_pos);
            if (tvalid && tready) begin
                if (idx >= len)
                    extra_acc++;
                idx++;
            end
        end
        start  = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // exp_gap: -2 means don't care; exp_under: -1 means don't care.
    task automatic verify(input string name, input bit tm, input int exp_gap, input int exp_under,
                          input bit exp_lasterr);
        check({name, " n_samples"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s sample%0d", name, i), (i < got_q.size()) ? got_q[i] : 16'hxxxx,
                  exp_q[i]);
        check({name, " sr_pc_last"}, last_pc, 1'b1);
        check({name, " sr_pc_before_last"}, prev_pc, 1'b0);
        check({name, " sr_lasterr"}, sr_lasterr, exp_lasterr);
        if (exp_under >= 0)
            check({name, " sr_underrun"}, sr_underrun, exp_under);
        if (exp_gap != -2)
            check({name, " first_gap"}, first_gap, exp_gap);
        if (tm)
            check({name, " tready_seen"}, tready_seen, 1'b0);
        check({name, " extra_accepts"}, extra_acc, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({name, " idle_pc"}, sr_pc, 1'b1);
            check({name, " idle_tready"}, tready, 1'b0);
            check({name, " idle_valid"}, dac_valid, 1'b0);
        end
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst tready", tready, 1'b0);
        check("rst dac_data", dac_data, 16'h0);
        check("rst dac_valid", dac_valid, 1'b0);
        check("rst sr_pc", sr_pc, 1'b0);
        check("rst sr_underrun", sr_underrun, 1'b0);
        check("rst sr_lasterr", sr_lasterr, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 check("rst sr_pc_before_edge", sr_pc, 1'b0);
        @(negedge clk);
        check("idle sr_pc", sr_pc, 1'b1);

        // Basic packet with fixed words, all buffered before playback
        fixed_words = '{32'h0001_0000, 32'h0003_0002, 32'h0005_0004, 32'h0007_0006};
        run_packet(4, 0, 3, 100, -1, 0, 0, 0);
        fixed_words.delete();
        verify("basic", 0, -1, 0, 0);

        // Source stall after the prime level forces an underrun gap after sample 15
        run_packet(16, 0, 15, 100, 8, 20, 0, 0);
        check("stall first_sample_idx", idx_at_first, 8);
        verify("stall", 0, 16, 1, 0);

        // Ramp mode
        run_packet(3, 1, 2, 100, -1, 0, 0, 0);
        verify("ramp", 1, -1, 0, 0);

        // tlast at the wrong position, then a clean packet clears the flag
        run_packet(4, 0, 1, 100, -1, 0, 0, 0);
        verify("badlast", 0, -1, 0, 1);
        run_packet(5, 0, 4, 100, -1, 0, 0, 0);
        verify("cleanlast", 0, -1, 0, 0);

        // Reset mid-playback aborts the packet; no residue afterwards
        run_packet(8, 0, 7, 100, -1, 0, 0, 3);
        rst = 1'b1;
        #1;
        check("abort dac_valid", dac_valid, 1'b0);
        check("abort dac_data", dac_data, 16'h0);
        check("abort sr_pc", sr_pc, 1'b0);
        check("abort tready", tready, 1'b0);
        check("abort sr_underrun", sr_underrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int stray = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (dac_valid)
                    stray++;
            end
            check("abort stray_valid", stray, 0);
        end
        run_packet(2, 0, 1, 100, -1, 0, 0, 0);
        verify("after_abort", 0, -1, 0, 0);

        // Zero-length start stays idle
        @(negedge clk);
        dsize = 0;
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("zero sr_pc", sr_pc, 1'b1);
            check("zero tready", tready, 1'b0);
            check("zero dac_valid", dac_valid, 1'b0);
        end
        start = 1'b0;

        // Start pulses and dsize/test changes mid-packet are ignored
        run_packet(4, 0, 3, 100, -1, 0, 1, 0);
        verify("noisy_start", 0, -1, 0, 0);

        // Randomized packets: continuous source, bursty source, ramp
        for (int r = 0; r < 6; r++) begin
            int rlen;
            int pct;
            bit rtm;
            rlen = $urandom_range(1, 24);
            pct  = (r % 2 == 0) ? 100 : 40;
            rtm  = (r == 5);
            run_packet(rlen, rtm, rlen - 1, pct, -1, 0, 1, 0);
            verify($sformatf("rand%0d", r), rtm, -2, (pct == 100 || rtm) ? 0 : -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_output_data_transmitter.md
Name: dac_output_data_transmitter

Overview:
- AXI-Stream slave that takes packets of 32-bit words, each holding two 16-bit samples, and replays them as a continuous 16-bit sample stream toward the DAC/output path, one sample per clock.
- Outbound counterpart of the ADC input receiver: same control set (dsize, start, test, sr_pc) and the same word packing (low half first).
- Contains a small synchronous FIFO, so the sample stream can start after a prime level and ride out short source stalls.

Parameters:
- FIFO_DEPTH, 16: FIFO depth in 32-bit words; power of two, 4..256.
- PRIME_LEVEL, 8: FIFO words required before playback starts; must be 1..FIFO_DEPTH.

Ports:
- s00_axis_aclk  in  1  Single clock for all logic.
- s00_axis_areset  in  1  Asynchronous, active-high reset.
- s00_axis_tvalid  in  1  AXIS valid.
- s00_axis_tdata  in  32  [15:0] = first sample, [31:16] = second sample.
- s00_axis_tkeep  in  4  Ignored.
- s00_axis_tlast  in  1  End-of-packet marker; checked only.
- s00_axis_tready  out  1  AXIS ready.
- dsize  in  32  Packet length in 32-bit words; sampled on an accepted start.
- start  in  1  Level; accepted only in IDLE.
- test  in  1  Ramp mode; sampled on an accepted start.
- dac_data  out  16  Output sample, registered.
- dac_valid  out  1  High on cycles where dac_data is a new sample.
- sr_pc  out  1  High while IDLE (packet complete / ready).
- sr_underrun  out  1  Sticky; FIFO ran dry mid-packet.
- sr_lasterr  out  1  Sticky; tlast position mismatch.

Behaviour:
- Reset values (asynchronous on reset high): state = IDLE, FIFO empty, all counters 0, s00_axis_tready = 0, dac_data = 0, dac_valid = 0, sr_pc = 0 until the first clock edge after reset release, sr_underrun = 0, sr_lasterr = 0.
- Reset mid-packet aborts the packet immediately. No residue may be played afterwards.
- States: IDLE, FILL, PLAY.
- IDLE:
  - sr_pc = 1, tready = 0.
  - On start: latch dsize → len and test → tmode; clear rx_cnt, tx_cnt, half, sr_underrun, sr_lasterr.
  - If len == 0, stay in IDLE (sr_pc stays 1). Otherwise go to FILL.
- Acceptance (FILL and PLAY, tmode = 0):
  - tready = !fifo_full && rx_cnt < len.
  - A word is accepted when tvalid && tready: push to FIFO, rx_cnt += 1.
  - Words beyond len are never accepted; tready stays 0 after len words.
- tlast check: on an accepted word, set sr_lasterr if tlast != (rx_cnt == len-1).
- FILL → PLAY when any of these holds:
  - fifo_count >= PRIME_LEVEL;
  - rx_cnt == len;
  - tmode = 1 (immediately).
- PLAY, tmode = 0:
  - Each cycle, if the FIFO is non-empty: emit the low or high half of the head word according to half, then toggle half.
  - The head word is popped on the same cycle its high half is emitted.
  - The emitted sample appears on dac_data with dac_valid = 1 on the following cycle (registered, latency 1).
  - Push and pop in the same cycle are legal; count is unchanged.
- Underrun: in PLAY with the FIFO empty and tx_cnt < len:
  - dac_valid = 0 and dac_data holds its last value;
  - sr_underrun is set;
  - stay in PLAY and resume automatically when data arrives.
- Completion:
  - On the cycle the high half of word len-1 is emitted, tx_cnt reaches len and state → IDLE.
  - The last dac_valid pulse and sr_pc = 1 occur on the same cycle.
  - Back-to-back packets are allowed: start held high re-arms on the cycle after IDLE entry.
- Test mode (tmode = 1):
  - tready = 0 throughout; the FIFO is unused.
  - PLAY emits a 16-bit ramp 0, 1, ..., 2*len-1, one sample per cycle, then → IDLE. The ramp wraps modulo 2^16.
- start in FILL or PLAY is ignored. dsize and test changes mid-packet are ignored.
- Counters are 32 bit. len = 0xFFFFFFFF must work (no overflow of rx_cnt/tx_cnt compares).

Decomposition:
- Package dac_output_pkg:
  - state enum type (IDLE, FILL, PLAY);
  - SAMPLE_W = 16 and WORD_W = 32 constants.
- Sub-module axis_sync_fifo:
  - single-clock FIFO parameterised by width and depth;
  - ports: push, pop, din, dout, full, empty, count;
  - first-word fall-through;
  - async active-high reset.

Test Plan:
- dsize=4, words 0x00010000, 0x00030002, 0x00050004, 0x00070006 (tlast on 4th), tvalid always → dac_data 0..7 on 8 consecutive dac_valid cycles, sr_pc high with the 8th, sr_lasterr = 0, sr_underrun = 0.
- dsize=16, PRIME_LEVEL=8, source sends 8 words then stalls 20 cycles then sends the rest → playback starts after the 8th word; dac_valid low during the gap after sample 15; sr_underrun = 1; all 32 samples in order.
- test=1, dsize=3, tvalid held high → dac_data 0,1,2,3,4,5 on consecutive cycles, tready never asserted, sr_pc high with the last sample.
- dsize=4 with tlast on word 1 and not on word 3 → sr_lasterr = 1; the next packet (start again) clears it.
- Reset pulse in PLAY after 3 samples of a dsize=8 packet → all outputs at reset values, no further dac_valid; a following dsize=2 packet plays only its own 4 samples.
- dsize=0 + start → stays IDLE, sr_pc = 1, tready = 0; start pulses during FILL/PLAY of a dsize=4 packet → no restart, exactly 8 samples.
